// File: rtl/alu_pkg.sv
// Shared ALU control codes, RV32 opcode/funct constants and the issue FSM state type.
package alu_pkg;

    localparam int WIDTH = 32;

    typedef enum logic [3:0] {
        ALU_NOT = 4'b0000,
        ALU_AND = 4'b0001,
        ALU_OR  = 4'b0010,
        ALU_XOR = 4'b0011,
        ALU_ADD = 4'b0100,
        ALU_SUB = 4'b0101,
        ALU_SHR = 4'b0110,
        ALU_SHL = 4'b0111,
        ALU_CMP = 4'b1000
    } alu_ctrl_e;

    localparam logic [6:0] OPC_R  = 7'b0110011;
    localparam logic [6:0] OPC_I  = 7'b0010011;
    localparam logic [6:0] OPC_BR = 7'b1100011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SRL  = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;

    localparam logic [6:0] F7_ZERO = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction-in, ALU-drive and result-out signal bundle of the issue controller.
// master = the issue controller, slave = register-read / ALU / writeback environment.
interface alu_issue_ctrl_if import alu_pkg::*; ();

    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [3:0]       alu_ctrl;
    logic [WIDTH-1:0] alu_op1;
    logic [WIDTH-1:0] alu_op2;
    logic [WIDTH-1:0] alu_out;
    logic             alu_carry;
    logic             alu_zero;
    logic             out_valid;
    logic             out_ready;
    logic [4:0]       rd_addr;
    logic [WIDTH-1:0] rd_data;
    logic             rd_we;
    logic             br_taken;
    logic             illegal;

    modport master (
        input  in_valid, instr, rs1_val, rs2_val, alu_out, alu_carry, alu_zero, out_ready,
        output in_ready, alu_ctrl, alu_op1, alu_op2, out_valid, rd_addr, rd_data, rd_we,
               br_taken, illegal
    );

    modport slave (
        output in_valid, instr, rs1_val, rs2_val, alu_out, alu_carry, alu_zero, out_ready,
        input  in_ready, alu_ctrl, alu_op1, alu_op2, out_valid, rd_addr, rd_data, rd_we,
               br_taken, illegal
    );

endinterface

// File: rtl/alu_dec.sv
// Decodes an RV32 R/I/branch instruction into ALU control, operands and outcome flags.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the decode is consumed.
module alu_dec import alu_pkg::*; (
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    output logic [3:0]       alu_ctrl,
    output logic [WIDTH-1:0] op1,
    output logic [WIDTH-1:0] op2,
    output logic             swap,
    output logic             is_branch,
    output logic             is_bne,
    output logic             illegal
);

    logic [6:0]       opcode;
    logic [2:0]       f3;
    logic [6:0]       f7;
    logic             is_r;
    logic             is_i;
    logic             f7_zero;
    logic [WIDTH-1:0] src2;
    logic [4:0]       shamt;
    logic             unused_fields;

    assign opcode  = instr[6:0];
    assign f3      = instr[14:12];
    assign f7      = instr[31:25];
    assign is_r    = (opcode == OPC_R);
    assign is_i    = (opcode == OPC_I);
    assign f7_zero = (f7 == F7_ZERO);
    assign src2    = is_i ? {{(WIDTH-12){instr[31]}}, instr[31:20]} : rs2_val;
    assign shamt   = is_i ? instr[24:20] : rs2_val[4:0];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    always_comb begin
        alu_ctrl  = ALU_ADD;
        op1       = rs1_val;
        op2       = src2;
        swap      = 1'b0;
        is_branch = 1'b0;
        is_bne    = 1'b0;
        illegal   = 1'b1;
        if (is_r || is_i) begin
            case (f3)
                F3_ADD: begin
                    if (is_i || f7_zero) begin
                        illegal = 1'b0;
                    end else if (f7 == F7_ALT) begin
                        alu_ctrl = ALU_SUB;
                        illegal  = 1'b0;
                    end
                end
                F3_XOR: if (is_i || f7_zero) begin alu_ctrl = ALU_XOR; illegal = 1'b0; end
                F3_OR:  if (is_i || f7_zero) begin alu_ctrl = ALU_OR;  illegal = 1'b0; end
                F3_AND: if (is_i || f7_zero) begin alu_ctrl = ALU_AND; illegal = 1'b0; end
                // shifts take only the 5-bit amount; a nonzero funct7 (SRA/SRAI) is unsupported
                F3_SLL: if (f7_zero) begin alu_ctrl = ALU_SHL; op2 = WIDTH'(shamt); illegal = 1'b0; end
                F3_SRL: if (f7_zero) begin alu_ctrl = ALU_SHR; op2 = WIDTH'(shamt); illegal = 1'b0; end
                F3_SLTU: begin
                    if (is_i || f7_zero) begin
                        // ALU only has "greater than", so rs1 < src2 becomes src2 > rs1
                        alu_ctrl = ALU_CMP;
                        op1      = src2;
                        op2      = rs1_val;
                        swap     = 1'b1;
                        illegal  = 1'b0;
                    end
                end
                default: ;
            endcase
        end else if (opcode == OPC_BR && (f3 == F3_BEQ || f3 == F3_BNE)) begin
            alu_ctrl  = ALU_SUB;
            op2       = rs2_val;
            is_branch = 1'b1;
            is_bne    = (f3 == F3_BNE);
            illegal   = 1'b0;
        end
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issues one instruction at a time to the external ALU and returns writeback/branch result.
// Latency: out_valid 2 cycles after accept (legal), 1 cycle (illegal); one instr per 3 cycles.
// Backpressure: in_ready only in IDLE; result held stable in DONE until out_ready.
module alu_issue_ctrl import alu_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    alu_issue_ctrl_if.master bus
);

    logic [3:0]       dec_ctrl;
    logic [WIDTH-1:0] dec_op1;
    logic [WIDTH-1:0] dec_op2;
    logic             dec_swap;
    logic             dec_branch;
    logic             dec_bne;
    logic             dec_illegal;

    state_e           state;
    state_e           state_nxt;
    logic             in_ready;
    logic             out_valid;

    logic [3:0]       alu_ctrl_q;
    logic [WIDTH-1:0] op1_q;
    logic [WIDTH-1:0] op2_q;
    logic [4:0]       pend_rd;
    logic             pend_swap;
    logic             pend_branch;
    logic             pend_bne;
    logic [4:0]       rd_addr_q;
    logic [WIDTH-1:0] rd_data_q;
    logic             rd_we_q;
    logic             br_taken_q;
    logic             illegal_q;

    alu_dec u_dec (
        .instr     (bus.instr),
        .rs1_val   (bus.rs1_val),
        .rs2_val   (bus.rs2_val),
        .alu_ctrl  (dec_ctrl),
        .op1       (dec_op1),
        .op2       (dec_op2),
        .swap      (dec_swap),
        .is_branch (dec_branch),
        .is_bne    (dec_bne),
        .illegal   (dec_illegal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (bus.in_valid) state_nxt = dec_illegal ? ST_DONE : ST_EXEC;
            ST_EXEC: state_nxt = ST_DONE;
            ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == ST_IDLE);
        out_valid = (state == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_ctrl_q  <= ALU_ADD;
            op1_q       <= '0;
            op2_q       <= '0;
            pend_rd     <= '0;
            pend_swap   <= 1'b0;
            pend_branch <= 1'b0;
            pend_bne    <= 1'b0;
            rd_addr_q   <= '0;
            rd_data_q   <= '0;
            rd_we_q     <= 1'b0;
            br_taken_q  <= 1'b0;
            illegal_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        pend_rd     <= bus.instr[11:7];
                        pend_swap   <= dec_swap;
                        pend_branch <= dec_branch;
                        pend_bne    <= dec_bne;
                        if (dec_illegal) begin
                            rd_addr_q <= bus.instr[11:7];
                            illegal_q <= 1'b1;
                        end else begin
                            alu_ctrl_q <= dec_ctrl;
                            op1_q      <= dec_op1;
                            op2_q      <= dec_op2;
                        end
                    end
                end
                ST_EXEC: begin
                    alu_ctrl_q <= ALU_ADD;
                    op1_q      <= '0;
                    op2_q      <= '0;
                    rd_addr_q  <= pend_rd;
                    rd_data_q  <= pend_swap ? {{(WIDTH-1){1'b0}}, bus.alu_carry} : bus.alu_out;
                    rd_we_q    <= !pend_branch && (pend_rd != 5'd0);
                    br_taken_q <= pend_branch && (bus.alu_zero ^ pend_bne);
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        rd_addr_q  <= '0;
                        rd_data_q  <= '0;
                        rd_we_q    <= 1'b0;
                        br_taken_q <= 1'b0;
                        illegal_q  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.alu_ctrl  = alu_ctrl_q;
    assign bus.alu_op1   = op1_q;
    assign bus.alu_op2   = op2_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_data   = rd_data_q;
    assign bus.rd_we     = rd_we_q;
    assign bus.br_taken  = br_taken_q;
    assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed vector bench for alu_issue_ctrl with a behavioural ALU attached.
module tb_alu_issue_ctrl;

    logic clk;
    logic rst_n;
    int   nchecks;
    int   nerr;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [32:0] alu_wide;
    always_comb begin
        alu_wide      = 33'd0;
        bus.alu_carry = 1'b0;
        case (bus.alu_ctrl)
            4'b0000: alu_wide = {1'b0, ~bus.alu_op1};
            4'b0001: alu_wide = {1'b0, bus.alu_op1 & bus.alu_op2};
            4'b0010: alu_wide = {1'b0, bus.alu_op1 | bus.alu_op2};
            4'b0011: alu_wide = {1'b0, bus.alu_op1 ^ bus.alu_op2};
            4'b0100: begin
                alu_wide      = {1'b0, bus.alu_op1} + {1'b0, bus.alu_op2};
                bus.alu_carry = alu_wide[32];
            end
            4'b0101: begin
                alu_wide      = {1'b0, bus.alu_op1} - {1'b0, bus.alu_op2};
                bus.alu_carry = (bus.alu_op1 < bus.alu_op2);
            end
            4'b0110: alu_wide = {1'b0, bus.alu_op1 >> bus.alu_op2[4:0]};
            4'b0111: alu_wide = {1'b0, bus.alu_op1 << bus.alu_op2[4:0]};
            4'b1000: bus.alu_carry = (bus.alu_op1 > bus.alu_op2);
            default: ;
        endcase
        bus.alu_out  = alu_wide[31:0];
        bus.alu_zero = (alu_wide[31:0] == 32'd0);
    end

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [3:0]  ctrl;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        ill;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        we;
        logic        br;
    } vec_t;

    localparam int NV = 13;
    vec_t vecs [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input int stall);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = v.instr;
        bus.rs1_val  = v.rs1;
        bus.rs2_val  = v.rs2;
        tick();
        bus.in_valid = 1'b0;
        bus.instr    = $urandom;
        bus.rs1_val  = $urandom;
        bus.rs2_val  = $urandom;
        chk({v.name, " in_ready busy"}, 32'(bus.in_ready), 32'd0);
        if (!v.ill) begin
            chk({v.name, " exec ctrl"}, 32'(bus.alu_ctrl), 32'(v.ctrl));
            chk({v.name, " exec op1"}, bus.alu_op1, v.op1);
            chk({v.name, " exec op2"}, bus.alu_op2, v.op2);
            chk({v.name, " exec out_valid"}, 32'(bus.out_valid), 32'd0);
            tick();
        end
        for (int s = 0; s <= stall; s++) begin
            if (s > 0) tick();
            chk({v.name, " out_valid"}, 32'(bus.out_valid), 32'd1);
            chk({v.name, " in_ready done"}, 32'(bus.in_ready), 32'd0);
            chk({v.name, " idle ctrl"}, 32'(bus.alu_ctrl), 32'h4);
            chk({v.name, " idle op1"}, bus.alu_op1, 32'd0);
            chk({v.name, " rd_addr"}, 32'(bus.rd_addr), 32'(v.rd));
            chk({v.name, " rd_data"}, bus.rd_data, v.data);
            chk({v.name, " rd_we"}, 32'(bus.rd_we), 32'(v.we));
            chk({v.name, " br_taken"}, 32'(bus.br_taken), 32'(v.br));
            chk({v.name, " illegal"}, 32'(bus.illegal), 32'(v.ill));
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        chk({v.name, " cleared out_valid"}, 32'(bus.out_valid), 32'd0);
        chk({v.name, " cleared in_ready"}, 32'(bus.in_ready), 32'd1);
        chk({v.name, " cleared rd_we"}, 32'(bus.rd_we), 32'd0);
        chk({v.name, " cleared illegal"}, 32'(bus.illegal), 32'd0);
    endtask

    initial begin
        nchecks = 0;
        nerr    = 0;
        //          name        instr         rs1           rs2          ctrl  op1           op2           ill rd data          we br
        vecs[0]  = '{"add",     32'h000001B3, 32'd5,        32'd7,        4'h4, 32'd5,        32'd7,        0, 3, 32'd12,        1, 0};
        vecs[1]  = '{"sub",     32'h400000B3, 32'd3,        32'd5,        4'h5, 32'd3,        32'd5,        0, 1, 32'hFFFFFFFE,  1, 0};
        vecs[2]  = '{"addi",    32'hFFF00113, 32'd0,        32'h1234,     4'h4, 32'd0,        32'hFFFFFFFF, 0, 2, 32'hFFFFFFFF,  1, 0};
        vecs[3]  = '{"sltu",    32'h000032B3, 32'd2,        32'd9,        4'h8, 32'd9,        32'd2,        0, 5, 32'd1,         1, 0};
        vecs[4]  = '{"sltu_sw", 32'h000032B3, 32'd9,        32'd2,        4'h8, 32'd2,        32'd9,        0, 5, 32'd0,         1, 0};
        vecs[5]  = '{"beq",     32'h00000463, 32'h55,       32'h55,       4'h5, 32'h55,       32'h55,       0, 8, 32'd0,         0, 1};
        vecs[6]  = '{"bne",     32'h00001463, 32'h55,       32'h55,       4'h5, 32'h55,       32'h55,       0, 8, 32'd0,         0, 0};
        vecs[7]  = '{"slli",    32'h00401213, 32'd1,        32'hFFFF,     4'h7, 32'd1,        32'd4,        0, 4, 32'h10,        1, 0};
        vecs[8]  = '{"srai",    32'h40405213, 32'd1,        32'd1,        4'h4, 32'd0,        32'd0,        1, 4, 32'd0,         0, 0};
        vecs[9]  = '{"slt",     32'h000022B3, 32'd1,        32'd2,        4'h4, 32'd0,        32'd0,        1, 5, 32'd0,         0, 0};
        vecs[10] = '{"add_x0",  32'h00000033, 32'd1,        32'd1,        4'h4, 32'd1,        32'd1,        0, 0, 32'd2,         0, 0};
        vecs[11] = '{"and",     32'h00007333, 32'hF0F0,     32'hFF00,     4'h1, 32'hF0F0,     32'hFF00,     0, 6, 32'hF000,      1, 0};
        vecs[12] = '{"srl",     32'h000053B3, 32'h80000000, 32'h21,       4'h6, 32'h80000000, 32'd1,        0, 7, 32'h40000000,  1, 0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.instr     = 32'd0;
        bus.rs1_val   = 32'd0;
        bus.rs2_val   = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset alu_ctrl", 32'(bus.alu_ctrl), 32'h4);
        chk("reset op1", bus.alu_op1, 32'd0);
        chk("reset op2", bus.alu_op2, 32'd0);
        chk("reset rd_data", bus.rd_data, 32'd0);
        chk("reset flags", 32'({bus.rd_addr, bus.rd_we, bus.br_taken, bus.illegal}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < NV; i++) run_vec(vecs[i], 0);

        // consumer stalls for 5 cycles: result must hold
        run_vec(vecs[0], 5);

        // reset pulse during EXEC discards the instruction
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = vecs[1].instr;
        bus.rs1_val  = vecs[1].rs1;
        bus.rs2_val  = vecs[1].rs2;
        tick();
        bus.in_valid = 1'b0;
        chk("rst exec ctrl", 32'(bus.alu_ctrl), 32'h5);
        rst_n = 1'b0;
        #1;
        chk("rst async out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst async in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst async ctrl", 32'(bus.alu_ctrl), 32'h4);
        chk("rst async op1", bus.alu_op1, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("post rst out_valid", 32'(bus.out_valid), 32'd0);
            chk("post rst in_ready", 32'(bus.in_ready), 32'd1);
        end

        // still operational after the reset pulse
        run_vec(vecs[7], 0);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
